// File: rtl/sortmax_trace_fifo_if.sv
// sortmax_trace_fifo_if: readout handshake (valid, ready, {timestamp, word} data); master drives valid/data, slave drives ready
interface sortmax_trace_fifo_if #(parameter int DW = 28);
  logic valid;
  logic ready;
  logic [DW-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/sortmax_trace_fifo.sv
// sortmax_trace_fifo: triggered capture of non-zero sortmax control words with timestamps into a FWFT FIFO; ports clk, rst (async, high), y_in, arm, disarm, trig_mask, ovf_clr, bus (valid/ready/data master), count, full, overflow, drop_cnt, state_o
module sortmax_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int W = 20,
  parameter int TS_W = 8,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic [W-1:0] y_in,
  input  logic arm,
  input  logic disarm,
  input  logic [W-1:0] trig_mask,
  input  logic ovf_clr,
  sortmax_trace_fifo_if.master bus,
  output logic [AW:0] count,
  output logic full,
  output logic overflow,
  output logic [7:0] drop_cnt,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, HALT = 2'd3} state_t;
  state_t state;
  logic [TS_W+W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0] ts;
  logic trig, halt_now, req, pop, push, drop;
  // With STOP_ON_FULL the edge that sees a full FIFO only moves to HALT; its word is neither stored nor counted as a drop.
  always_comb begin
    trig = |(y_in & trig_mask);
    halt_now = STOP_ON_FULL && state == CAPTURE && full;
    req = !disarm && !halt_now && ((state == ARMED && trig) || (state == CAPTURE && |y_in));
    pop = bus.valid && bus.ready;
    push = req && (!full || pop);
    drop = req && full && !pop && !STOP_ON_FULL;
  end
  assign full = count == (AW+1)'(DEPTH);
  assign bus.valid = count != '0;
  assign bus.data = bus.valid ? mem[rd_ptr] : '0;
  assign state_o = state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ts <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      state <= disarm ? IDLE : (state == IDLE && arm) ? ARMED : (state == ARMED && trig) ? CAPTURE : halt_now ? HALT : state;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + {7'd0, ~&drop_cnt};
      end
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {ts, y_in};
endmodule

// File: tb/tb_sortmax_trace_fifo.sv
// tb_sortmax_trace_fifo: directed checks of trigger, filtering, overflow, full push+pop, halt and async reset
module tb_sortmax_trace_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic [19:0] y_in = '0, trig_mask = '0;
  logic arm = 1'b0, disarm = 1'b0, ovf_clr = 1'b0, out_ready = 1'b0;
  logic [3:0] count0, count1;
  logic full0, full1, ovf0, ovf1;
  logic [7:0] drop0, drop1;
  logic [1:0] st0, st1;
  int checks = 0, errors = 0;
  sortmax_trace_fifo_if #(.DW(28)) bus0();
  sortmax_trace_fifo_if #(.DW(28)) bus1();
  assign bus0.ready = out_ready;
  assign bus1.ready = out_ready;
  always #5 clk = ~clk;
  sortmax_trace_fifo #(.STOP_ON_FULL(1'b0)) d0 (.clk(clk), .rst(rst), .y_in(y_in), .arm(arm), .disarm(disarm),
    .trig_mask(trig_mask), .ovf_clr(ovf_clr), .bus(bus0), .count(count0), .full(full0), .overflow(ovf0),
    .drop_cnt(drop0), .state_o(st0));
  sortmax_trace_fifo #(.STOP_ON_FULL(1'b1)) d1 (.clk(clk), .rst(rst), .y_in(y_in), .arm(arm), .disarm(disarm),
    .trig_mask(trig_mask), .ovf_clr(ovf_clr), .bus(bus1), .count(count1), .full(full1), .overflow(ovf1),
    .drop_cnt(drop1), .state_o(st1));
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    {y_in, trig_mask, arm, disarm, ovf_clr, out_ready} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
    checks++; if (bus0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus0.valid); end
    checks++; if (bus0.data !== 28'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus0.data); end
    checks++; if ({st0, full0, ovf0, drop0} !== 12'h0) begin errors++; $display("FAIL reset_flags got %h exp 000", {st0, full0, ovf0, drop0}); end
  endtask
  task automatic test_trigger();
    do_reset();
    arm = 1'b1; trig_mask = 20'h00004; tick();
    arm = 1'b0;
    checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL trig_armed got %0d exp 1", st0); end
    y_in = 20'h00002; repeat (4) tick();
    checks++; if (count0 !== 4'd0 || st0 !== 2'd1) begin errors++; $display("FAIL trig_nomatch got count %0d state %0d exp 0 1", count0, st0); end
    y_in = 20'h00006; tick();
    checks++; if (bus0.data !== {8'd5, 20'h00006}) begin errors++; $display("FAIL trig_entry got %h exp %h", bus0.data, {8'd5, 20'h00006}); end
    checks++; if (count0 !== 4'd1 || bus0.valid !== 1'b1 || st0 !== 2'd2) begin errors++; $display("FAIL trig_state got count %0d valid %b state %0d exp 1 1 2", count0, bus0.valid, st0); end
  endtask
  task automatic test_mask_zero();
    do_reset();
    arm = 1'b1; tick();
    arm = 1'b0; y_in = 20'hFFFFF; repeat (3) tick();
    checks++; if (st0 !== 2'd1 || count0 !== 4'd0) begin errors++; $display("FAIL mask_zero got state %0d count %0d exp 1 0", st0, count0); end
  endtask
  task automatic test_filter();
    do_reset();
    arm = 1'b1; trig_mask = 20'h00001; tick();
    arm = 1'b0;
    y_in = 20'h00001; tick();
    y_in = 20'h00000; tick();
    y_in = 20'h00080; tick();
    y_in = 20'h00000; tick();
    checks++; if (count0 !== 4'd2) begin errors++; $display("FAIL filter_count got %0d exp 2", count0); end
    checks++; if (bus0.data !== {8'd1, 20'h00001}) begin errors++; $display("FAIL filter_hold got %h exp %h", bus0.data, {8'd1, 20'h00001}); end
    out_ready = 1'b1; tick();
    checks++; if (bus0.data !== {8'd3, 20'h00080} || count0 !== 4'd1) begin errors++; $display("FAIL filter_second got %h cnt %0d exp %h 1", bus0.data, count0, {8'd3, 20'h00080}); end
    tick();
    checks++; if (bus0.valid !== 1'b0 || bus0.data !== 28'h0 || count0 !== 4'd0) begin errors++; $display("FAIL filter_empty got valid %b data %h cnt %0d exp 0 0 0", bus0.valid, bus0.data, count0); end
    tick();
    checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL ready_on_empty got %0d exp 0", count0); end
    out_ready = 1'b0;
  endtask
  task automatic test_overflow_and_full_pushpop();
    do_reset();
    arm = 1'b1; trig_mask = 20'hFFFFF; tick();
    arm = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      y_in = 20'(i); tick();
    end
    checks++; if (count0 !== 4'd8 || full0 !== 1'b1) begin errors++; $display("FAIL ovf_full got cnt %0d full %b exp 8 1", count0, full0); end
    checks++; if (ovf0 !== 1'b1 || drop0 !== 8'd2) begin errors++; $display("FAIL ovf_drop got ovf %b drop %0d exp 1 2", ovf0, drop0); end
    checks++; if (bus0.data !== {8'd1, 20'h00001}) begin errors++; $display("FAIL ovf_head got %h exp %h", bus0.data, {8'd1, 20'h00001}); end
    y_in = '0; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    checks++; if (ovf0 !== 1'b0 || drop0 !== 8'd0 || count0 !== 4'd8) begin errors++; $display("FAIL ovf_clr got ovf %b drop %0d cnt %0d exp 0 0 8", ovf0, drop0, count0); end
    out_ready = 1'b1; y_in = 20'hABCDE; tick();
    checks++; if (count0 !== 4'd8 || drop0 !== 8'd0 || ovf0 !== 1'b0) begin errors++; $display("FAIL full_pushpop got cnt %0d drop %0d ovf %b exp 8 0 0", count0, drop0, ovf0); end
    checks++; if (bus0.data !== {8'd2, 20'h00002}) begin errors++; $display("FAIL full_pushpop_head got %h exp %h", bus0.data, {8'd2, 20'h00002}); end
    y_in = '0; repeat (7) tick();
    checks++; if (bus0.data !== {8'd12, 20'hABCDE} || count0 !== 4'd1) begin errors++; $display("FAIL full_pushpop_tail got %h cnt %0d exp %h 1", bus0.data, count0, {8'd12, 20'hABCDE}); end
    out_ready = 1'b0;
  endtask
  task automatic test_halt();
    do_reset();
    arm = 1'b1; trig_mask = 20'hFFFFF; tick();
    arm = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      y_in = 20'(i); tick();
    end
    checks++; if (count1 !== 4'd8 || st1 !== 2'd2) begin errors++; $display("FAIL halt_fill got cnt %0d state %0d exp 8 2", count1, st1); end
    y_in = 20'd9; tick();
    checks++; if (st1 !== 2'd3 || drop1 !== 8'd0 || ovf1 !== 1'b0) begin errors++; $display("FAIL halt_enter got state %0d drop %0d ovf %b exp 3 0 0", st1, drop1, ovf1); end
    y_in = 20'd10; arm = 1'b1; tick();
    arm = 1'b0;
    checks++; if (st1 !== 2'd3 || count1 !== 4'd8 || drop1 !== 8'd0 || bus1.data !== {8'd1, 20'h00001}) begin errors++; $display("FAIL halt_ignore got state %0d cnt %0d drop %0d head %h exp 3 8 0 %h", st1, count1, drop1, bus1.data, {8'd1, 20'h00001}); end
    y_in = '0; disarm = 1'b1; arm = 1'b1; tick();
    {disarm, arm} = '0;
    checks++; if (st1 !== 2'd0 || count1 !== 4'd8) begin errors++; $display("FAIL halt_disarm got state %0d cnt %0d exp 0 8", st1, count1); end
  endtask
  task automatic test_async_reset();
    do_reset();
    arm = 1'b1; trig_mask = 20'hFFFFF; tick();
    arm = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      y_in = 20'(i); tick();
    end
    checks++; if (count0 !== 4'd5 || st0 !== 2'd2) begin errors++; $display("FAIL areset_pre got cnt %0d state %0d exp 5 2", count0, st0); end
    rst = 1'b1;
    #1;
    checks++; if (bus0.valid !== 1'b0 || count0 !== 4'd0 || st0 !== 2'd0 || bus0.data !== 28'h0) begin errors++; $display("FAIL areset got valid %b cnt %0d state %0d data %h exp 0 0 0 0", bus0.valid, count0, st0, bus0.data); end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_trigger();
    test_mask_zero();
    test_filter();
    test_overflow_and_full_pushpop();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
